// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch stage and IF/ID pipeline register for a five-stage MIPS
//   core. It holds the F-stage PC and drives the instruction memory word
//   address. It picks the next PC from four sources: sequential, branch, j/jal
//   or jr/jalr. Redirect targets are built from the D-stage fields. The fetched
//   word and its PC are registered into the D stage.
//
//   Optional feature macro: FETCH_EXC_EN
//     When this macro is defined, the block flags misaligned or out-of-range
//     fetches. A flagged fetch loads a nop with d_valid = 1 and sets d_exc_adel.
//     When it is undefined, the d_exc_adel port is absent, and out-of-range
//     addresses wrap modulo the instruction memory.
//
//   Ports
//     clk        in   rising-edge clock
//     reset      in   asynchronous active-low reset
//     stall      in   freeze F PC and IF/ID (has priority over flush)
//     flush      in   load a bubble into IF/ID
//     npc_sel    in   0 = PC+4, 1 = branch, 2 = j/jal, 3 = jr/jalr
//     d_imm16    in   D-stage imm16 (branch offset)
//     d_imm26    in   D-stage imm26 (jump index)
//     d_rs_val   in   forwarded rs value (jr target)
//     im_rdata   in   instruction word read combinationally at im_addr
//     im_addr    out  word index (f_pc - IM_BASE) >> 2, low 12 bits
//     f_pc       out  current F-stage PC
//     d_instr    out  IF/ID instruction
//     d_pc       out  IF/ID PC
//     d_pc8      out  d_pc + 8 (link address)
//     d_valid    out  IF/ID holds a real fetched instruction
//     d_exc_adel out  (FETCH_EXC_EN only) fetch address error flag
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [1:0]  npc_sel,
  input  logic [15:0] d_imm16,
  input  logic [25:0] d_imm26,
  input  logic [31:0] d_rs_val,
  input  logic [31:0] im_rdata,
  output logic [11:0] im_addr,
  output logic [31:0] f_pc,
  output logic [31:0] d_instr,
  output logic [31:0] d_pc,
  output logic [31:0] d_pc8,
`ifdef FETCH_EXC_EN
  output logic        d_exc_adel,
`endif
  output logic        d_valid
);

  localparam logic [1:0] NPC_SEQ = 2'd0;
  localparam logic [1:0] NPC_BR  = 2'd1;
  localparam logic [1:0] NPC_J   = 2'd2;
  localparam logic [1:0] NPC_JR  = 2'd3;

  logic [31:0] f_pc_q,    f_pc_d;
  logic [31:0] d_instr_q, d_instr_d;
  logic [31:0] d_pc_q,    d_pc_d;
  logic        d_valid_q, d_valid_d;

  logic [31:0] pc_off;
  logic [31:0] d_pc4;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [31:0] npc;
  logic        fetch_bad;

  // The word index is relative to the memory base. Only the low 12 bits
  // are kept, so any address wraps modulo the memory.
  assign pc_off  = f_pc_q - IM_BASE;
  assign im_addr = pc_off[13:2];

  // The branch and jump targets are relative to the delay-slot address
  // (d_pc + 4). The jump takes its top nibble from d_pc + 4, which picks
  // up the carry when d_pc is the last word of a 256 MB region.
  assign d_pc4     = d_pc_q + 32'd4;
  assign br_target = d_pc4 + {{14{d_imm16[15]}}, d_imm16, 2'b00};
  assign j_target  = {d_pc4[31:28], d_imm26, 2'b00};

  always_comb begin
    npc = f_pc_q + 32'd4;
    case (npc_sel)
      NPC_SEQ: npc = f_pc_q + 32'd4;
      NPC_BR:  npc = br_target;
      NPC_J:   npc = j_target;
      NPC_JR:  npc = d_rs_val;
      default: npc = f_pc_q + 32'd4;
    endcase
  end

`ifdef FETCH_EXC_EN
  localparam logic [31:0] IM_LAST = IM_BASE + 32'(IM_WORDS) * 32'd4 - 32'd4;
  assign fetch_bad = (f_pc_q[1:0] != 2'b00) || (f_pc_q < IM_BASE) || (f_pc_q > IM_LAST);
`else
  assign fetch_bad = 1'b0;
`endif

  // Stall takes priority over flush, and flush takes priority over a
  // normal fetch. A flagged fetch still counts as a valid slot. Its word
  // is replaced by a nop so that no garbage reaches decode.
  always_comb begin
    f_pc_d    = f_pc_q;
    d_instr_d = d_instr_q;
    d_pc_d    = d_pc_q;
    d_valid_d = d_valid_q;
    if (!stall) begin
      f_pc_d = npc;
      d_pc_d = f_pc_q;
      if (flush) begin
        d_instr_d = 32'd0;
        d_valid_d = 1'b0;
      end else begin
        d_instr_d = fetch_bad ? 32'd0 : im_rdata;
        d_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      f_pc_q    <= RESET_PC;
      d_instr_q <= 32'd0;
      d_pc_q    <= 32'd0;
      d_valid_q <= 1'b0;
    end else begin
      f_pc_q    <= f_pc_d;
      d_instr_q <= d_instr_d;
      d_pc_q    <= d_pc_d;
      d_valid_q <= d_valid_d;
    end
  end

`ifdef FETCH_EXC_EN
  logic exc_q, exc_d;

  always_comb begin
    exc_d = exc_q;
    if (!stall) begin
      exc_d = flush ? 1'b0 : fetch_bad;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exc_q <= 1'b0;
    end else begin
      exc_q <= exc_d;
    end
  end

  assign d_exc_adel = exc_q;
`endif

  assign f_pc    = f_pc_q;
  assign d_instr = d_instr_q;
  assign d_pc    = d_pc_q;
  assign d_pc8   = d_pc_q + 32'd8;
  assign d_valid = d_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//   Directed testbench for fetch_stage. Every expected value below is
//   computed by hand. Inputs change 1 ns after a rising edge, and outputs
//   are checked before the next rising edge.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic [1:0]  npc_sel;
  logic [15:0] d_imm16;
  logic [25:0] d_imm26;
  logic [31:0] d_rs_val;
  logic [31:0] im_rdata;
  logic [11:0] im_addr;
  logic [31:0] f_pc;
  logic [31:0] d_instr;
  logic [31:0] d_pc;
  logic [31:0] d_pc8;
  logic        d_valid;
`ifdef FETCH_EXC_EN
  logic        d_exc_adel;
`endif

  int n_cmp;
  int n_bad;

  fetch_stage dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .flush     (flush),
    .npc_sel   (npc_sel),
    .d_imm16   (d_imm16),
    .d_imm26   (d_imm26),
    .d_rs_val  (d_rs_val),
    .im_rdata  (im_rdata),
    .im_addr   (im_addr),
    .f_pc      (f_pc),
    .d_instr   (d_instr),
    .d_pc      (d_pc),
    .d_pc8     (d_pc8),
`ifdef FETCH_EXC_EN
    .d_exc_adel(d_exc_adel),
`endif
    .d_valid   (d_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end else begin
      $display("ok   %s: %08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    reset    = 1'b0;
    stall    = 1'b0;
    flush    = 1'b0;
    npc_sel  = 2'd0;
    d_imm16  = 16'd0;
    d_imm26  = 26'd0;
    d_rs_val = 32'd0;
    im_rdata = 32'h2408_0005;

    // Reset state while reset is held through several edges.
    tick();
    tick();
    chk("rst_f_pc",    f_pc,    32'h0000_3000);
    chk("rst_d_instr", d_instr, 32'h0);
    chk("rst_d_pc",    d_pc,    32'h0);
    chk("rst_d_pc8",   d_pc8,   32'h8);
    chk("rst_d_valid", {31'd0, d_valid}, 32'd0);

    // Release reset between edges. The first fetch happens at the next edge.
    reset = 1'b1;
    #1;
    chk("rel_f_pc",    f_pc,    32'h0000_3000);
    chk("rel_im_addr", {20'd0, im_addr}, 32'd0);
    chk("rel_d_valid", {31'd0, d_valid}, 32'd0);
    tick();
    chk("f1_d_instr",  d_instr, 32'h2408_0005);
    chk("f1_d_pc",     d_pc,    32'h0000_3000);
    chk("f1_d_pc8",    d_pc8,   32'h0000_3008);
    chk("f1_f_pc",     f_pc,    32'h0000_3004);
    chk("f1_d_valid",  {31'd0, d_valid}, 32'd1);
    chk("f1_im_addr",  {20'd0, im_addr}, 32'd1);

    // Two sequential fetches bring the branch word (at 3008) into D.
    im_rdata = 32'h1111_0001;
    tick();
    chk("f2_f_pc",    f_pc,    32'h0000_3008);
    chk("f2_d_instr", d_instr, 32'h1111_0001);
    im_rdata = 32'h1000_FFFE;
    tick();
    chk("f3_f_pc",    f_pc,    32'h0000_300C);
    chk("f3_d_pc",    d_pc,    32'h0000_3008);

    // Taken branch with imm16 = -2 gives 3008 + 4 - 8 = 3004. The delay
    // slot fetched at 300C lands in IF/ID.
    npc_sel  = 2'd1;
    d_imm16  = 16'hFFFE;
    im_rdata = 32'h2222_000C;
    tick();
    chk("br_f_pc",    f_pc,    32'h0000_3004);
    chk("br_d_pc",    d_pc,    32'h0000_300C);
    chk("br_d_instr", d_instr, 32'h2222_000C);

    // jr to 3010, then one sequential step, so that d_pc = 3010.
    npc_sel  = 2'd3;
    d_rs_val = 32'h0000_3010;
    tick();
    chk("jr1_f_pc", f_pc, 32'h0000_3010);
    npc_sel = 2'd0;
    tick();
    chk("seq_d_pc", d_pc, 32'h0000_3010);

    // j: top nibble of 3014 is 0, and C10 << 2 = 3040.
    npc_sel = 2'd2;
    d_imm26 = 26'h000_0C10;
    tick();
    chk("j_f_pc", f_pc, 32'h0000_3040);

    // jr to 3100.
    npc_sel  = 2'd3;
    d_rs_val = 32'h0000_3100;
    im_rdata = 32'h3333_3040;
    tick();
    chk("jr_f_pc",    f_pc,    32'h0000_3100);
    chk("jr_d_pc",    d_pc,    32'h0000_3040);
    chk("jr_d_instr", d_instr, 32'h3333_3040);

    // Stall beats both flush and a jump request.
    stall    = 1'b1;
    flush    = 1'b1;
    npc_sel  = 2'd2;
    im_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stl%0d_f_pc", i),    f_pc,    32'h0000_3100);
      chk($sformatf("stl%0d_d_instr", i), d_instr, 32'h3333_3040);
      chk($sformatf("stl%0d_d_pc", i),    d_pc,    32'h0000_3040);
      chk($sformatf("stl%0d_d_valid", i), {31'd0, d_valid}, 32'd1);
    end

    // A flush without stall inserts a bubble while the PC advances by 4.
    stall   = 1'b0;
    npc_sel = 2'd0;
    tick();
    chk("fl_d_instr", d_instr, 32'h0);
    chk("fl_d_valid", {31'd0, d_valid}, 32'd0);
    chk("fl_f_pc",    f_pc,    32'h0000_3104);
    chk("fl_d_pc",    d_pc,    32'h0000_3100);
    flush = 1'b0;

`ifndef FETCH_EXC_EN
    // Jump nibble carry: d_pc = 0FFFFFFC, so the nibble comes from 10000000.
    npc_sel  = 2'd3;
    d_rs_val = 32'h0FFF_FFFC;
    tick();
    npc_sel = 2'd0;
    tick();
    chk("jc_d_pc", d_pc, 32'h0FFF_FFFC);
    npc_sel = 2'd2;
    d_imm26 = 26'h000_0010;
    tick();
    chk("jc_f_pc", f_pc, 32'h1000_0040);

    // PC wraps from FFFFFFFC to 0. The im_addr index wraps modulo the memory.
    npc_sel  = 2'd3;
    d_rs_val = 32'hFFFF_FFFC;
    tick();
    chk("wr_im_addr", {20'd0, im_addr}, 32'h0000_03FF);
    npc_sel = 2'd0;
    tick();
    chk("wr_f_pc", f_pc, 32'h0);
`endif

    // Asserting reset between edges forces the registers at once.
    #2;
    reset = 1'b0;
    #1;
    chk("mr_f_pc",    f_pc,    32'h0000_3000);
    chk("mr_d_valid", {31'd0, d_valid}, 32'd0);
    chk("mr_d_pc",    d_pc,    32'h0);
    tick();
    reset = 1'b1;

`ifdef FETCH_EXC_EN
    chk("ex_rst", {31'd0, d_exc_adel}, 32'd0);
    npc_sel  = 2'd3;
    d_rs_val = 32'h0000_3002;
    im_rdata = 32'h4444_0000;
    tick();
    chk("ex0_f_pc", f_pc, 32'h0000_3002);
    chk("ex0_exc",  {31'd0, d_exc_adel}, 32'd0);
    d_rs_val = 32'h0000_7000;
    tick();
    chk("ex1_exc",   {31'd0, d_exc_adel}, 32'd1);
    chk("ex1_instr", d_instr, 32'h0);
    chk("ex1_valid", {31'd0, d_valid}, 32'd1);
    d_rs_val = 32'h0000_3004;
    tick();
    chk("ex2_exc",   {31'd0, d_exc_adel}, 32'd1);
    chk("ex2_instr", d_instr, 32'h0);
    npc_sel = 2'd0;
    tick();
    chk("ex3_exc",   {31'd0, d_exc_adel}, 32'd0);
    chk("ex3_instr", d_instr, 32'h4444_0000);
`else
    npc_sel  = 2'd0;
    im_rdata = 32'h4444_0000;
    tick();
    chk("post_d_instr", d_instr, 32'h4444_0000);
    chk("post_f_pc",    f_pc,    32'h0000_3004);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
